// File: rtl/rv_fork_fifo.sv
// FIFO-buffered ready/valid broadcast: the head entry is forked to NUM_OUT consumers
// that may each accept in a different cycle; the entry retires once every consumer has taken it.
module rv_fork_fifo #(
  parameter int DATA_WIDTH  = 16,
  parameter int DATA2_WIDTH = 13,
  parameter int NUM_OUT     = 3,
  parameter int DEPTH       = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [DATA_WIDTH-1:0]           in_data,
  input  logic signed [DATA2_WIDTH-1:0]   in_data2,
  input  logic                            in_valid,
  output logic                            in_ready,
  output logic [NUM_OUT*DATA_WIDTH-1:0]   out_data,
  output logic [NUM_OUT*DATA2_WIDTH-1:0]  out_data2,
  output logic [NUM_OUT-1:0]              out_valid,
  input  logic [NUM_OUT-1:0]              out_ready,
  output logic [$clog2(DEPTH+1)-1:0]      level
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  logic [DATA_WIDTH-1:0]         mem_data  [DEPTH];
  logic signed [DATA2_WIDTH-1:0] mem_data2 [DEPTH];
  logic [PW-1:0]                 wr_ptr, rd_ptr;
  logic [CW-1:0]                 count;
  logic [NUM_OUT-1:0]            done, acc;
  logic                          nonempty, push, pop;

  // Handshake: a transfer happens on a channel in any cycle where its valid and ready are both 1.
  // in_ready comes only from registered occupancy, so no combinational path runs from
  // out_ready back to the producer.
  assign nonempty = (count != '0);
  assign in_ready = (count < DEPTH_C) && !rst;
  assign push     = in_valid && in_ready;
  assign acc      = out_valid & out_ready;
  // The head retires once every channel has either accepted earlier or accepts now.
  assign pop      = nonempty && (&(done | out_ready));
  assign level    = count;

  for (genvar i = 0; i < NUM_OUT; i++) begin : g_out
    assign out_data[i*DATA_WIDTH +: DATA_WIDTH]    = mem_data[rd_ptr];
    assign out_data2[i*DATA2_WIDTH +: DATA2_WIDTH] = mem_data2[rd_ptr];
    assign out_valid[i] = nonempty && !done[i] && !rst;
  end

  // Storage is intentionally left out of reset; only the control state is cleared.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr]  <= in_data;
      mem_data2[wr_ptr] <= in_data2;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      done   <= '0;
    end else begin
      if (push) begin
        wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
        done   <= '0;
      end else begin
        done <= done | acc;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule
